// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: {op, rd, rs1, rs2, imm} in, packed words with addresses out.
// Define INST_ENC_LI_EN to enable the LI pseudo-op (op 38), which may expand to LUI + ADDI.
module inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT1 = 2'd1;
`ifdef INST_ENC_LI_EN
    localparam logic [1:0] ST_EMIT2 = 2'd2;
`endif

    logic [1:0]        state_q, state_d;
    logic [31:0]       out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              enc_ok;
    logic [31:0]       enc_w0;
    logic [2:0]        f3;
    logic              fits12, fits13, fits21, shamt_ok;
    logic              out_hs, accept;
`ifdef INST_ENC_LI_EN
    logic [31:0]       pend_q, pend_d;
    logic              enc_two;
    logic [31:0]       enc_w1;
    logic [19:0]       li_hi;
    // (imm + 0x800) >> 12: rounds so the sign-extended ADDI low part lands on imm
    assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
`endif

    // Signed-range checks: upper bits must be a pure sign extension
    assign fits12   = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13   = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21   = (&in_imm[31:20]) | ~(|in_imm[31:20]);
    assign shamt_ok = ~(|in_imm[31:5]);

    always_comb begin
        f3 = 3'd0;
        case (in_op)
            6'd5, 6'd11, 6'd16, 6'd24, 6'd29:        f3 = 3'd1;
            6'd12, 6'd17, 6'd19, 6'd30:              f3 = 3'd2;
            6'd20, 6'd31:                            f3 = 3'd3;
            6'd6, 6'd13, 6'd21, 6'd32:               f3 = 3'd4;
            6'd7, 6'd14, 6'd25, 6'd26, 6'd33, 6'd34: f3 = 3'd5;
            6'd8, 6'd22, 6'd35:                      f3 = 3'd6;
            6'd9, 6'd23, 6'd36:                      f3 = 3'd7;
            default:                                 f3 = 3'd0;
        endcase
    end

    always_comb begin
        enc_ok = 1'b0;
        enc_w0 = '0;
`ifdef INST_ENC_LI_EN
        enc_two = 1'b0;
        enc_w1  = '0;
`endif
        case (in_op)
            6'd0, 6'd1: begin
                enc_ok = ~(|in_imm[11:0]);
                enc_w0 = {in_imm[31:12], in_rd, (in_op == 6'd0) ? 7'h37 : 7'h17};
            end
            6'd2: begin
                enc_ok = fits21 & ~in_imm[0];
                enc_w0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
            end
            6'd3: begin
                enc_ok = fits12;
                enc_w0 = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
            end
            6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9: begin
                enc_ok = fits13 & ~in_imm[0];
                enc_w0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                          in_imm[4:1], in_imm[11], 7'h63};
            end
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14: begin
                enc_ok = fits12;
                enc_w0 = {in_imm[11:0], in_rs1, f3, in_rd, 7'h03};
            end
            6'd15, 6'd16, 6'd17: begin
                enc_ok = fits12;
                enc_w0 = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'h23};
            end
            6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23: begin
                enc_ok = fits12;
                enc_w0 = {in_imm[11:0], in_rs1, f3, in_rd, 7'h13};
            end
            6'd24, 6'd25, 6'd26: begin
                enc_ok = shamt_ok;
                enc_w0 = {1'b0, in_op == 6'd26, 5'd0, in_imm[4:0], in_rs1, f3, in_rd, 7'h13};
            end
            6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36: begin
                enc_ok = 1'b1;
                enc_w0 = {1'b0, (in_op == 6'd28) | (in_op == 6'd34), 5'd0,
                          in_rs2, in_rs1, f3, in_rd, 7'h33};
            end
            6'd37: begin
                enc_ok = 1'b1;
                enc_w0 = 32'h0000_0073;
            end
`ifdef INST_ENC_LI_EN
            6'd38: begin
                enc_ok = 1'b1;
                if (fits12) begin
                    enc_w0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'h13};
                end else begin
                    enc_w0  = {li_hi, in_rd, 7'h37};
                    enc_two = |in_imm[11:0];
                    enc_w1  = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'h13};
                end
            end
`endif
            default: enc_ok = 1'b0;
        endcase
    end

    assign out_valid = (state_q != ST_IDLE);
    assign in_ready  = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_EMIT1) & out_ready));
    assign out_hs    = out_valid & out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        out_inst_d = out_inst_q;
        out_addr_d = out_addr_q;
        err_d      = 1'b0;
        err_cnt_d  = err_cnt_q;
`ifdef INST_ENC_LI_EN
        pend_d     = pend_q;
`endif
        if (flush) begin
            state_d    = ST_IDLE;
            out_addr_d = BASE_ADDR;
            err_cnt_d  = '0;
        end else begin
            if (out_hs) begin
                out_addr_d = out_addr_q + ADDR_W'(4);
            end
            case (state_q)
                ST_EMIT1: if (out_hs) state_d = ST_IDLE;
`ifdef INST_ENC_LI_EN
                ST_EMIT2: if (out_hs) begin
                    state_d    = ST_EMIT1;
                    out_inst_d = pend_q;
                end
`endif
                default: state_d = state_q;
            endcase
            // An accept only happens when no word remains held, so a reject leaves IDLE
            if (accept) begin
                if (enc_ok) begin
                    out_inst_d = enc_w0;
                    state_d    = ST_EMIT1;
`ifdef INST_ENC_LI_EN
                    if (enc_two) begin
                        state_d = ST_EMIT2;
                        pend_d  = enc_w1;
                    end
`endif
                end else begin
                    err_d = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_inst_q <= '0;
            out_addr_q <= BASE_ADDR;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
`ifdef INST_ENC_LI_EN
            pend_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            out_inst_q <= out_inst_d;
            out_addr_q <= out_addr_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
`ifdef INST_ENC_LI_EN
            pend_q     <= pend_d;
`endif
        end
    end

    assign out_inst  = out_inst_q;
    assign out_addr  = out_addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign dbg_state = state_q;

endmodule
